// File: rtl/riscv_core_div.sv
// Iterative restoring radix-2 integer divider for RV64 M-extension DIV/DIVU/REM/REMU and W variants.
// Divides one quotient bit per cycle. Zero-divisor and signed-overflow cases bypass the iteration loop.
module riscv_core_div #(
    parameter int XLEN = 64  // must exceed 32 so the word variants have upper bits to extend
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_div_start,
    input  logic [1:0]      i_div_op,
    input  logic            i_div_word,
    input  logic [XLEN-1:0] i_div_rs1,
    input  logic [XLEN-1:0] i_div_rs2,
    input  logic            i_div_flush,
    output logic            o_div_busy,
    output logic            o_div_valid,
    output logic [XLEN-1:0] o_div_result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg;
    logic [XLEN-1:0] quot_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] divisor_reg;
    logic [CW-1:0]   cnt_reg;
    logic            sel_rem_reg;
    logic            word_reg;
    logic            special_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            busy_reg;
    logic            valid_reg;
    logic [XLEN-1:0] result_reg;

    // Operand decode for the incoming request.
    logic            is_signed;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, dividend_load;
    logic            a_neg, b_neg, div_zero, overflow;

    always_comb begin
        is_signed = ~i_div_op[0];
        if (i_div_word) begin
            a_ext   = is_signed ? {{(XLEN-32){i_div_rs1[31]}}, i_div_rs1[31:0]}
                                : {{(XLEN-32){1'b0}}, i_div_rs1[31:0]};
            b_ext   = is_signed ? {{(XLEN-32){i_div_rs2[31]}}, i_div_rs2[31:0]}
                                : {{(XLEN-32){1'b0}}, i_div_rs2[31:0]};
            min_neg = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            a_ext   = i_div_rs1;
            b_ext   = i_div_rs2;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg    = is_signed & a_ext[XLEN-1];
        b_neg    = is_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        overflow = is_signed & (a_ext == min_neg) & (&b_ext);
        // Word dividends sit in the top half so 32 shifts consume exactly their bits.
        dividend_load = i_div_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
    end

    // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    logic [XLEN:0]   partial;
    logic            sub_ok;
    logic [XLEN-1:0] rem_iter, quot_iter;

    always_comb begin
        partial   = {rem_reg, quot_reg[XLEN-1]};
        sub_ok    = (partial >= {1'b0, divisor_reg});
        rem_iter  = sub_ok ? (partial[XLEN-1:0] - divisor_reg) : partial[XLEN-1:0];
        quot_iter = {quot_reg[XLEN-2:0], sub_ok};
    end

    // Sign fix-up, quotient/remainder select and word sign extension.
    logic [XLEN-1:0] q_src, r_src, q_fix, r_fix, sel_val, final_res;

    always_comb begin
        q_src     = special_reg ? quot_reg : quot_iter;
        r_src     = special_reg ? rem_reg  : rem_iter;
        q_fix     = neg_q_reg ? -q_src : q_src;
        r_fix     = neg_r_reg ? -r_src : r_src;
        sel_val   = sel_rem_reg ? r_fix : q_fix;
        final_res = word_reg ? {{(XLEN-32){sel_val[31]}}, sel_val[31:0]} : sel_val;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            quot_reg    <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            sel_rem_reg <= 1'b0;
            word_reg    <= 1'b0;
            special_reg <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            result_reg  <= '0;
        end else if (i_div_flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    if (i_div_start) begin
                        state_reg   <= CALC;
                        busy_reg    <= 1'b1;
                        sel_rem_reg <= i_div_op[1];
                        word_reg    <= i_div_word;
                        divisor_reg <= b_mag;
                        cnt_reg     <= i_div_word ? CW'(32) : CW'(XLEN);
                        special_reg <= div_zero | overflow;
                        neg_q_reg   <= ~div_zero & ~overflow & (a_neg ^ b_neg);
                        neg_r_reg   <= ~div_zero & ~overflow & a_neg;
                        // Special cases preload their final quotient/remainder directly.
                        if (div_zero) begin
                            quot_reg <= '1;
                            rem_reg  <= a_ext;
                        end else if (overflow) begin
                            quot_reg <= a_ext;
                            rem_reg  <= '0;
                        end else begin
                            quot_reg <= dividend_load;
                            rem_reg  <= '0;
                        end
                    end
                end
                CALC: begin
                    if (special_reg || cnt_reg == CW'(1)) begin
                        state_reg  <= DONE;
                        valid_reg  <= 1'b1;
                        result_reg <= final_res;
                    end else begin
                        quot_reg <= quot_iter;
                        rem_reg  <= rem_iter;
                        cnt_reg  <= cnt_reg - CW'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_div_busy   = busy_reg;
    assign o_div_valid  = valid_reg;
    assign o_div_result = result_reg;

endmodule

// File: tb/tb_riscv_core_div.sv
// Self-checking bench for riscv_core_div: directed corner cases plus randomized operations
// compared against an arithmetic reference model of RISC-V division semantics.
module tb_riscv_core_div;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_div_start;
    logic [1:0]  i_div_op;
    logic        i_div_word;
    logic [63:0] i_div_rs1;
    logic [63:0] i_div_rs2;
    logic        i_div_flush;
    logic        o_div_busy;
    logic        o_div_valid;
    logic [63:0] o_div_result;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    riscv_core_div #(.XLEN(64)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_div_start  (i_div_start),
        .i_div_op     (i_div_op),
        .i_div_word   (i_div_word),
        .i_div_rs1    (i_div_rs1),
        .i_div_rs2    (i_div_rs2),
        .i_div_flush  (i_div_flush),
        .o_div_busy   (o_div_busy),
        .o_div_valid  (o_div_valid),
        .o_div_result (o_div_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension results computed with native 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic        sgn;
        logic [63:0] x, y, q, r, res;
        sgn = ~op[0];
        if (word) begin
            x = sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
            y = sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
        end else begin
            x = a;
            y = b;
        end
        if (y == 64'h0) begin
            q = '1;
            r = x;
        end else if (sgn && x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF) begin
            q = x;
            r = 64'h0;
        end else if (sgn) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        res = op[1] ? r : q;
        if (word) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
        logic sgn, bz, ovf;
        sgn = ~op[0];
        bz  = word ? (b[31:0] == 32'h0) : (b == 64'h0);
        ovf = sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        if (bz || ovf) return 1;
        return word ? 32 : 64;
    endfunction

    // Issue one operation, scramble inputs afterwards, optionally re-pulse start while busy.
    task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input int restart_at);
        logic [63:0] exp;
        int          lat;
        int          k;
        bit          seen;
        exp = ref_result(op, word, a, b);
        lat = ref_latency(op, word, a, b);
        @(negedge i_clk);
        i_div_start = 1'b1;
        i_div_op    = op;
        i_div_word  = word;
        i_div_rs1   = a;
        i_div_rs2   = b;
        @(negedge i_clk);
        i_div_start = 1'b0;
        i_div_op    = ~op;
        i_div_word  = ~word;
        i_div_rs1   = {$urandom, $urandom};
        i_div_rs2   = {$urandom, $urandom};
        check("busy_after_start", {63'h0, o_div_busy}, 64'h1);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 100) begin
            @(negedge i_clk);
            k++;
            if (o_div_valid) begin
                seen = 1'b1;
            end else begin
                i_div_start = (k == restart_at);
            end
        end
        i_div_start = 1'b0;
        check("latency", 64'(k), 64'(lat));
        check("result", o_div_result, exp);
        @(negedge i_clk);
        check("valid_one_cycle", {63'h0, o_div_valid}, 64'h0);
        check("busy_after_done", {63'h0, o_div_busy}, 64'h0);
        check("result_hold", o_div_result, exp);
        $display("op=%0d word=%0d rs1=%h rs2=%h -> %h (latency %0d)", op, word, a, b, exp, lat);
    endtask

    // Observe a window and require that no valid pulse appears and busy stays low at the end.
    task automatic watch_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_clk);
            if (o_div_valid) pulses++;
        end
        check({tag, "_no_valid"}, 64'(pulses), 64'h0);
        check({tag, "_idle"}, {63'h0, o_div_busy}, 64'h0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic        rword;
        logic [63:0] ra, rb;
        int          mode;

        i_rst_n     = 1'b0;
        i_div_start = 1'b0;
        i_div_op    = 2'b00;
        i_div_word  = 1'b0;
        i_div_rs1   = '0;
        i_div_rs2   = '0;
        i_div_flush = 1'b0;
        repeat (2) @(negedge i_clk);
        check("reset_busy", {63'h0, o_div_busy}, 64'h0);
        check("reset_valid", {63'h0, o_div_valid}, 64'h0);
        check("reset_result", o_div_result, 64'h0);
        i_rst_n = 1'b1;

        // Directed corner cases.
        run_op(2'b01, 1'b0, 64'd100, 64'd7, 0);
        run_op(2'b11, 1'b0, 64'd100, 64'd7, 0);
        run_op(2'b00, 1'b0, -64'sd7, 64'd2, 0);
        run_op(2'b10, 1'b0, -64'sd7, 64'd2, 0);
        run_op(2'b00, 1'b0, 64'd5, 64'd0, 0);
        run_op(2'b10, 1'b0, 64'd5, 64'd0, 0);
        run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 0);
        run_op(2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF, 0);
        run_op(2'b11, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0000, 0);
        run_op(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);

        // Second start while busy is ignored.
        run_op(2'b00, 1'b0, 64'd1_000_003, -64'sd13, 10);

        // Start, ignored restart at cycle 10, flush at cycle 20.
        @(negedge i_clk);
        i_div_start = 1'b1;
        i_div_op    = 2'b01;
        i_div_word  = 1'b0;
        i_div_rs1   = 64'd999;
        i_div_rs2   = 64'd10;
        @(negedge i_clk);
        i_div_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge i_clk);
            i_div_start = (c == 10);
            i_div_flush = (c == 20);
        end
        @(negedge i_clk);
        i_div_flush = 1'b0;
        i_div_start = 1'b0;
        check("flush_busy_drop", {63'h0, o_div_busy}, 64'h0);
        watch_quiet("flush", 80);
        $display("flush mid-calc: busy cleared, no valid");

        // Flush wins over a simultaneous start in IDLE.
        @(negedge i_clk);
        i_div_start = 1'b1;
        i_div_flush = 1'b1;
        @(negedge i_clk);
        i_div_start = 1'b0;
        i_div_flush = 1'b0;
        check("flush_vs_start_busy", {63'h0, o_div_busy}, 64'h0);
        watch_quiet("flush_vs_start", 70);
        $display("flush with start in idle: start ignored");

        // Reset mid-CALC clears outputs immediately and nothing follows release.
        run_op(2'b01, 1'b0, 64'd77, 64'd3, 0);
        @(negedge i_clk);
        i_div_start = 1'b1;
        i_div_rs1   = 64'd500;
        i_div_rs2   = 64'd9;
        @(negedge i_clk);
        i_div_start = 1'b0;
        repeat (15) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'h0, o_div_busy}, 64'h0);
        check("rst_mid_valid", {63'h0, o_div_valid}, 64'h0);
        check("rst_mid_result", o_div_result, 64'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        watch_quiet("rst_release", 80);
        check("rst_release_result", o_div_result, 64'h0);
        $display("reset mid-calc: outputs cleared, no valid after release");

        // Randomized operations with biased corner cases.
        for (int n = 0; n < 40; n++) begin
            rop   = 2'($urandom_range(0, 3));
            rword = 1'($urandom_range(0, 1));
            ra    = {$urandom, $urandom};
            rb    = {$urandom, $urandom};
            mode  = int'($urandom_range(0, 7));
            case (mode)
                0: rb = rword ? {$urandom, 32'h0} : 64'h0;
                1: rb = {$urandom, 32'h0} | 64'($urandom_range(1, 15));
                2: begin
                    ra = rword ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    rb = rword ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                3: rb = -64'($urandom_range(1, 9));
                4: ra = 64'($urandom_range(0, 50));
                default: ;
            endcase
            run_op(rop, rword, ra, rb, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/riscv_core_div.md
RISCV_CORE_DIV -- requirements
Module: riscv_core_div

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits.
REQ-002 SHALL have port i_clk  input  1  single core clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_div_start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port i_div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port i_div_word  input  1  1 = RV64 W-variant (32-bit operation).
REQ-007 SHALL have port i_div_rs1  input  XLEN  dividend.
REQ-008 SHALL have port i_div_rs2  input  XLEN  divisor.
REQ-009 SHALL have port i_div_flush  input  1  synchronous abort of any operation in progress.
REQ-010 SHALL have port o_div_busy  output  1  high while an operation is accepted and not yet completed.
REQ-011 SHALL have port o_div_valid  output  1  one-cycle pulse marking o_div_result valid.
REQ-012 SHALL have port o_div_result  output  XLEN  quotient or remainder per i_div_op; feeds the writeback result-select mux.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE -> CALC on i_div_start=1 and i_div_flush=0; op, word flag and operands latched at that edge (E0); later input changes SHALL NOT affect the operation.
REQ-015 CALC SHALL perform one restoring radix-2 iteration per cycle: N=XLEN iterations (N=32 when word=1); after the last iteration CALC -> DONE.
REQ-016 DONE SHALL last exactly one cycle with o_div_valid=1, then return to IDLE.
REQ-017 For a normal operation o_div_valid SHALL be high in the cycle following edge E0+N (64-bit: edge E0+64; word: E0+32).
REQ-018 o_div_busy SHALL be 1 in CALC and DONE, 0 in IDLE; i_div_start while busy SHALL be ignored.
REQ-019 Divisor zero (after word truncation): SHALL skip CALC, enter DONE at E0+1; quotient = all ones, remainder = dividend.
REQ-020 Signed overflow (DIV/REM, dividend = most negative, divisor = -1): SHALL skip CALC; quotient = dividend, remainder = 0.
REQ-021 Signed ops SHALL divide magnitudes; quotient negated when operand signs differ; remainder takes dividend sign.
REQ-022 Word ops SHALL use bits [31:0] of each operand (sign-extended for DIVW/REMW, zero-extended for DIVUW/REMUW) and SHALL sign-extend bit 31 of the 32-bit result to XLEN, including unsigned variants.
REQ-023 o_div_result SHALL hold its value from DONE until the next DONE.
REQ-024 i_div_flush=1 SHALL force IDLE at the next edge with no o_div_valid pulse; flush wins over simultaneous start.

Reset
REQ-025 i_rst_n=0 SHALL immediately force IDLE, o_div_busy=0, o_div_valid=0, o_div_result=0, clear all internal registers.
REQ-026 Reset asserted mid-CALC SHALL abort the operation; no o_div_valid SHALL follow reset release.

Verification
REQ-027 DIVU rs1=100, rs2=7 -> valid 64 cycles after start edge, result 14; REMU same operands -> 2.
REQ-028 DIV rs1=-7, rs2=2 -> -3 (0xFFFF_FFFF_FFFF_FFFD); REM -> -1.
REQ-029 DIV rs2=0, rs1=5 -> valid at E0+1, result 0xFFFF_FFFF_FFFF_FFFF; REM -> 5.
REQ-030 DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> result 0x8000_0000_0000_0000, valid at E0+1; REM -> 0.
REQ-031 DIVUW rs1=0x0000_0000_FFFF_FFFE, rs2=1 -> valid after 32 iterations, result 0xFFFF_FFFF_FFFF_FFFE.
REQ-032 start, then second start at cycle 10 and flush at cycle 20 -> busy drops after flush edge, no valid pulse; reset mid-CALC -> same, outputs all 0.
